parallel_fir_reload: RTL and testbench

Parametrised successor to the fixed 8-lane Shannon-Whitaker lowpass. The block is an NSAMP-samples-per-clock direct-form FIR with NTAPS runtime-reloadable coefficients. It uses a double-buffered (shadow/active) coefficient bank, a bypass mode, round-half-up and saturating output, and a fixed pipeline latency. It sits directly after the ADC sample demux, ahead of the trigger/beamforming path.

---
 rtl/parallel_fir_reload.sv | 172 +++++++++++++++++
 tb/tb_parallel_fir_reload.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_fir_reload.sv
// Multi-lane direct-form FIR (NSAMP samples/clock) with double-buffered, runtime-reloadable
// coefficients, bypass, round-half-up and saturation; fixed four-clock latency.
module parallel_fir_reload #(
   parameter int unsigned NSAMP      = 8,
   parameter int unsigned INBITS     = 12,
   parameter int unsigned OUTBITS    = 12,
   parameter int unsigned NTAPS      = 15,
   parameter int unsigned COEFF_BITS = 18,
   parameter int unsigned FRAC_BITS  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NSAMP*INBITS-1:0]    in_i,
   input  logic                       bypass_i,
   output logic [NSAMP*OUTBITS-1:0]   out_o,
   input  logic [COEFF_BITS-1:0]      coeff_dat_i,
   input  logic                       coeff_valid_i,
   output logic                       coeff_ready_o,
   input  logic                       coeff_commit_i,
   output logic                       coeff_err_o,
   output logic                       coeff_full_o
);

   localparam int unsigned HIST  = (NTAPS - 1 + NSAMP - 1) / NSAMP;
   localparam int unsigned NHIST = HIST * NSAMP;
   localparam int unsigned NWIN  = NHIST + NSAMP;
   localparam int unsigned PW    = INBITS + COEFF_BITS;
   localparam int unsigned ACCW  = PW + $clog2(NTAPS);
   localparam int unsigned SW    = ACCW + 1;
   localparam int unsigned CNTW  = $clog2(NTAPS + 1);
   localparam int unsigned CTAP  = (NTAPS - 1) / 2;

   localparam logic signed [SW-1:0] P_RND = SW'(64'd1 << (FRAC_BITS - 1));
   localparam logic signed [SW-1:0] P_MAX = SW'((64'd1 << (OUTBITS - 1)) - 64'd1);
   localparam logic signed [SW-1:0] P_MIN = ~P_MAX;

   typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_FULL} state_t;

   function automatic logic signed [COEFF_BITS-1:0] f_imp(input int t);
      return (t == int'(CTAP)) ? COEFF_BITS'(64'd1 << FRAC_BITS) : '0;
   endfunction

   function automatic logic [OUTBITS-1:0] f_sat(input logic signed [SW-1:0] v);
      if (v > P_MAX)      return P_MAX[OUTBITS-1:0];
      else if (v < P_MIN) return P_MIN[OUTBITS-1:0];
      else                return v[OUTBITS-1:0];
   endfunction

   state_t                  r_state, w_state_nxt;
   logic [CNTW-1:0]         r_cnt, w_cnt_nxt;
   logic                    w_wr, w_commit, w_err_nxt;
   logic                    r_ready, r_full, r_err;

   logic signed [COEFF_BITS-1:0] r_shadow  [NTAPS];
   logic signed [COEFF_BITS-1:0] r_active  [NTAPS];
   logic signed [COEFF_BITS-1:0] r_coef_s1 [NTAPS];

   logic signed [INBITS-1:0] r_x     [NWIN];
   logic signed [INBITS-1:0] r_bx_s2 [NSAMP];
   logic signed [INBITS-1:0] r_bx_s3 [NSAMP];
   logic                     r_byp_s1, r_byp_s2, r_byp_s3;
   logic signed [PW-1:0]     r_prod  [NSAMP][NTAPS];
   logic signed [ACCW-1:0]   r_acc   [NSAMP];
   logic signed [ACCW-1:0]   w_sum   [NSAMP];
   logic signed [SW-1:0]     w_rnd   [NSAMP];
   logic [NSAMP*OUTBITS-1:0] r_out;

   // Loader next-state: a commit that is not in FULL is flagged and otherwise ignored
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wr        = 1'b0;
      w_commit    = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_EMPTY, S_LOADING: begin
            if (coeff_valid_i) begin
               w_wr        = 1'b1;
               w_cnt_nxt   = r_cnt + CNTW'(1);
               w_state_nxt = (r_cnt == CNTW'(NTAPS - 1)) ? S_FULL : S_LOADING;
            end
            w_err_nxt = coeff_commit_i;
         end
         S_FULL: begin
            if (coeff_commit_i) begin
               w_commit    = 1'b1;
               w_state_nxt = S_EMPTY;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_EMPTY;
         r_cnt   <= '0;
         r_ready <= 1'b1;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= (w_state_nxt != S_FULL);
         r_full  <= (w_state_nxt == S_FULL);
         r_err   <= w_err_nxt;
      end
   end

   // Shadow/active coefficient banks
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int t = 0; t < int'(NTAPS); t++) begin
            r_shadow[t] <= f_imp(t);
            r_active[t] <= f_imp(t);
         end
      end else begin
         for (int t = 0; t < int'(NTAPS); t++) begin
            if (w_wr && (r_cnt == CNTW'(t))) r_shadow[t] <= coeff_dat_i;
            if (w_commit)                    r_active[t] <= r_shadow[t];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < int'(NSAMP); k++) begin
         w_sum[k] = '0;
         for (int t = 0; t < int'(NTAPS); t++) w_sum[k] = w_sum[k] + ACCW'(r_prod[k][t]);
         w_rnd[k] = (SW'(r_acc[k]) + P_RND) >>> FRAC_BITS;
      end
   end

   // Coefficients ride with the stage-1 samples so a commit never splits an input clock
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int j = 0; j < int'(NWIN); j++) r_x[j] <= '0;
         for (int t = 0; t < int'(NTAPS); t++) r_coef_s1[t] <= f_imp(t);
         for (int k = 0; k < int'(NSAMP); k++) begin
            r_bx_s2[k] <= '0;
            r_bx_s3[k] <= '0;
            r_acc[k]   <= '0;
            for (int t = 0; t < int'(NTAPS); t++) r_prod[k][t] <= '0;
         end
         r_byp_s1 <= 1'b0;
         r_byp_s2 <= 1'b0;
         r_byp_s3 <= 1'b0;
         r_out    <= '0;
      end else begin
         for (int j = 0; j < int'(NHIST); j++) r_x[j] <= r_x[j + int'(NSAMP)];
         for (int k = 0; k < int'(NSAMP); k++) r_x[int'(NHIST) + k] <= in_i[INBITS*k +: INBITS];
         for (int t = 0; t < int'(NTAPS); t++) r_coef_s1[t] <= r_active[t];
         r_byp_s1 <= bypass_i;
         r_byp_s2 <= r_byp_s1;
         r_byp_s3 <= r_byp_s2;
         for (int k = 0; k < int'(NSAMP); k++) begin
            for (int t = 0; t < int'(NTAPS); t++)
               r_prod[k][t] <= PW'(r_x[int'(NHIST) + k - t]) * PW'(r_coef_s1[t]);
            r_bx_s2[k] <= r_x[int'(NHIST) + k];
            r_bx_s3[k] <= r_bx_s2[k];
            r_acc[k]   <= w_sum[k];
            r_out[OUTBITS*k +: OUTBITS] <= r_byp_s3 ? f_sat(SW'(r_bx_s3[k])) : f_sat(w_rnd[k]);
         end
      end
   end

   assign out_o         = r_out;
   assign coeff_ready_o = r_ready;
   assign coeff_full_o  = r_full;
   assign coeff_err_o   = r_err;

endmodule

// File: tb/tb_parallel_fir_reload.sv
// Directed bench for parallel_fir_reload: impulse responses, coefficient loader,
// rounding/saturation, reset mid-load and bypass latency.
module tb_parallel_fir_reload;

   localparam int NS = 8;
   localparam int IB = 12;
   localparam int OB = 12;
   localparam int CB = 18;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [NS*IB-1:0]  in_i;
   logic              bypass_i;
   logic [NS*OB-1:0]  out_o;
   logic [CB-1:0]     coeff_dat_i;
   logic              coeff_valid_i;
   logic              coeff_ready_o;
   logic              coeff_commit_i;
   logic              coeff_err_o;
   logic              coeff_full_o;

   int n_tests = 0;
   int n_fail  = 0;
   int sine_tab [30];
   logic [NS*IB-1:0] hist [34];

   parallel_fir_reload dut (
      .clk_i(clk_i), .rst_i(rst_i), .in_i(in_i), .bypass_i(bypass_i), .out_o(out_o),
      .coeff_dat_i(coeff_dat_i), .coeff_valid_i(coeff_valid_i), .coeff_ready_o(coeff_ready_o),
      .coeff_commit_i(coeff_commit_i), .coeff_err_o(coeff_err_o), .coeff_full_o(coeff_full_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      in_i = '0;
      repeat (n) step();
   endtask

   task automatic chk(input string tag, input logic [NS*OB-1:0] got, input logic [NS*OB-1:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [NS*OB-1:0] lanes(input int lo, input int hi, input int v);
      logic [NS*OB-1:0] r;
      r = '0;
      for (int k = lo; k <= hi; k++) r[OB*k +: OB] = OB'(v);
      return r;
   endfunction

   // One-clock impulse; output clocks 4 and 5 after it carry e4/e5, all others zero
   task automatic pulse(input string tag, input int lane, input int val,
                        input logic [NS*OB-1:0] e4, input logic [NS*OB-1:0] e5);
      in_i = '0;
      in_i[IB*lane +: IB] = IB'(val);
      for (int c = 1; c <= 7; c++) begin
         step();
         in_i = '0;
         chk($sformatf("%s_c%0d", tag, c), out_o, (c == 4) ? e4 : (c == 5) ? e5 : '0);
      end
   endtask

   task automatic load(input int n, input int val);
      for (int i = 0; i < n; i++) begin
         coeff_valid_i = 1'b1;
         coeff_dat_i   = CB'(val);
         step();
      end
      coeff_valid_i = 1'b0;
   endtask

   task automatic do_commit();
      coeff_commit_i = 1'b1;
      step();
      coeff_commit_i = 1'b0;
   endtask

   task automatic dc(input string tag, input int v, input int exp);
      in_i = lanes(0, NS - 1, v);
      repeat (8) step();
      chk(tag, out_o, lanes(0, NS - 1, exp));
   endtask

   task automatic drive_sine(input int c);
      for (int k = 0; k < NS; k++) in_i[IB*k +: IB] = IB'(sine_tab[(c * NS + k) % 30]);
   endtask

   initial begin
      rst_i          = 1'b1;
      in_i           = '0;
      bypass_i       = 1'b0;
      coeff_dat_i    = '0;
      coeff_valid_i  = 1'b0;
      coeff_commit_i = 1'b0;
      for (int i = 0; i < 30; i++)
         sine_tab[i] = $rtoi(2000.0 * $sin(2.0 * 3.141592653589793 * 11.0 * real'(i) / 30.0));

      // Reset state
      repeat (3) step();
      chk("out_in_reset", out_o, '0);
      rst_i = 1'b0;
      step();
      chk("out_after_reset", out_o, '0);
      chk1("ready_after_reset", coeff_ready_o, 1'b1);
      chk1("full_after_reset", coeff_full_o, 1'b0);
      chk1("err_after_reset", coeff_err_o, 1'b0);

      // Reset coefficients are a 7-sample delay
      idle(8);
      pulse("imp_l0", 0, 1000, lanes(7, 7, 1000), '0);
      idle(8);
      pulse("imp_l3", 3, 1000, '0, lanes(2, 2, 1000));

      // 15 taps of 1/16
      load(14, 4096);
      chk1("ready_w14", coeff_ready_o, 1'b1);
      chk1("full_w14", coeff_full_o, 1'b0);
      load(1, 4096);
      chk1("ready_w15", coeff_ready_o, 1'b0);
      chk1("full_w15", coeff_full_o, 1'b1);
      load(1, 0);
      chk1("full_ignore", coeff_full_o, 1'b1);
      do_commit();
      chk1("ready_commit", coeff_ready_o, 1'b1);
      chk1("full_commit", coeff_full_o, 1'b0);
      chk1("err_commit", coeff_err_o, 1'b0);
      idle(8);
      pulse("avg16", 0, 1000, lanes(0, 7, 63), lanes(0, 6, 63));

      // Near-unity taps: saturation and rounding
      load(15, 65535);
      do_commit();
      dc("sat_pos", 2047, 2047);
      dc("sat_neg", -2048, -2048);
      dc("rnd_p1", 1, 15);
      dc("rnd_m1", -1, -15);

      // Reset during a partial load with a sine running
      for (int c = 0; c < 5; c++) begin
         drive_sine(c);
         coeff_valid_i = 1'b1;
         coeff_dat_i   = CB'(1000);
         step();
      end
      coeff_valid_i = 1'b0;
      drive_sine(5);
      rst_i = 1'b1;
      #1;
      chk("out_async_rst", out_o, '0);
      step();
      drive_sine(6);
      step();
      chk("out_held_rst", out_o, '0);
      rst_i = 1'b0;
      in_i  = '0;
      step();
      chk1("ready_rst_rel", coeff_ready_o, 1'b1);
      chk1("full_rst_rel", coeff_full_o, 1'b0);
      idle(8);
      pulse("imp_after_rst", 0, 1000, lanes(7, 7, 1000), '0);

      // Early commit is an error and leaves the partial load intact
      load(7, 4096);
      do_commit();
      chk1("err_early", coeff_err_o, 1'b1);
      chk1("ready_early", coeff_ready_o, 1'b1);
      step();
      chk1("err_one_clk", coeff_err_o, 1'b0);
      idle(8);
      pulse("imp_after_err", 0, 1000, lanes(7, 7, 1000), '0);
      load(8, 4096);
      chk1("full_after_8", coeff_full_o, 1'b1);
      do_commit();
      chk1("err_good", coeff_err_o, 1'b0);
      chk1("full_good", coeff_full_o, 1'b0);
      idle(8);
      pulse("avg16_b", 0, 1000, lanes(0, 7, 63), lanes(0, 6, 63));

      // Last word and commit together: word kept, commit rejected
      load(14, 8192);
      coeff_valid_i  = 1'b1;
      coeff_dat_i    = CB'(8192);
      coeff_commit_i = 1'b1;
      step();
      coeff_valid_i  = 1'b0;
      coeff_commit_i = 1'b0;
      chk1("err_last_word", coeff_err_o, 1'b1);
      chk1("full_last_word", coeff_full_o, 1'b1);
      idle(8);
      pulse("avg16_c", 0, 1000, lanes(0, 7, 63), lanes(0, 6, 63));
      do_commit();
      chk1("err_late_commit", coeff_err_o, 1'b0);
      idle(8);
      pulse("avg8", 0, 1000, lanes(0, 7, 125), lanes(0, 6, 125));

      // Bypass: sine reproduced four clocks later, no blanking at the switch
      for (int c = 0; c < 34; c++) begin
         bypass_i = 1'b1;
         drive_sine(c);
         hist[c] = in_i;
         step();
         if (c >= 3) chk($sformatf("byp_c%0d", c), out_o, hist[c - 3]);
      end
      bypass_i = 1'b0;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
